// File: rtl/trap_controller.sv
// trap_controller: sequences machine-mode traps and mret around the CSR file.
// Flow per request: IDLE -> FLUSH (drain pipeline) -> COMMIT (CSR override) -> REDIRECT (fetch).
module trap_controller #(
    parameter int unsigned WORD_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              exc_valid,
    input  logic [WORD_W-1:0] exc_cause,
    input  logic [WORD_W-1:0] exc_pc,
    input  logic              mret_valid,
    input  logic              irq_msi,
    input  logic              irq_mti,
    input  logic              irq_mei,
    input  logic [WORD_W-1:0] commit_pc,
    input  logic              flush_ack,
    input  logic              csr_interrupt_en,
    input  logic [WORD_W-1:0] csr_mie,
    input  logic [1:0]        csr_mtvec_mode,
    input  logic [29:0]       csr_mtvec_base,
    input  logic [WORD_W-1:0] csr_mepc,
    output logic              csr_exception,
    output logic              csr_mret,
    output logic [WORD_W-1:0] csr_exception_cause,
    output logic [WORD_W-1:0] csr_exception_pc,
    output logic              flush_req,
    output logic              redirect_valid,
    output logic [WORD_W-1:0] redirect_pc,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE,
        FLUSH,
        COMMIT,
        REDIRECT
    } state_t;

    typedef enum logic {
        KIND_TRAP,
        KIND_MRET
    } kind_t;

    localparam logic [WORD_W-1:0] IRQ_FLAG = {1'b1, {(WORD_W-1){1'b0}}};

    state_t            state_q, state_d;
    kind_t             kind_q, kind_d;
    logic [WORD_W-1:0] cause_q, cause_d;
    logic [WORD_W-1:0] pc_q, pc_d;
    logic [WORD_W-1:0] rpc_q, rpc_d;

    logic              mei_en, msi_en, mti_en;
    logic              is_irq;
    logic [WORD_W-1:0] vec_base;
    logic [WORD_W-1:0] vec_off;
    logic [WORD_W-1:0] target;
    logic              unused_bits;

    assign mei_en = irq_mei & csr_mie[11] & csr_interrupt_en;
    assign msi_en = irq_msi & csr_mie[3]  & csr_interrupt_en;
    assign mti_en = irq_mti & csr_mie[7]  & csr_interrupt_en;

    // Exception causes never have the top bit set, so it marks a latched interrupt.
    assign is_irq   = cause_q[WORD_W-1];
    assign vec_base = WORD_W'({csr_mtvec_base, 2'b00});
    assign vec_off  = WORD_W'({cause_q[4:0], 2'b00});

    assign unused_bits = ^csr_mie;

    // Redirect target; sampled into rpc_q during COMMIT while mtvec/mepc are stable.
    always_comb begin
        target = vec_base;
        if (kind_q == KIND_MRET) begin
            target = csr_mepc;
        end else if (is_irq && (csr_mtvec_mode == 2'd1)) begin
            target = vec_base + vec_off;
        end
    end

    // Next-state, request latching and redirect target capture.
    always_comb begin
        state_d = state_q;
        kind_d  = kind_q;
        cause_d = cause_q;
        pc_d    = pc_q;
        rpc_d   = '0;
        unique case (state_q)
            IDLE: begin
                if (exc_valid) begin
                    kind_d  = KIND_TRAP;
                    cause_d = exc_cause;
                    pc_d    = exc_pc;
                    state_d = FLUSH;
                end else if (mret_valid) begin
                    kind_d  = KIND_MRET;
                    cause_d = '0;
                    pc_d    = '0;
                    state_d = FLUSH;
                end else if (mei_en || msi_en || mti_en) begin
                    kind_d  = KIND_TRAP;
                    pc_d    = '0;
                    state_d = FLUSH;
                    if (mei_en) begin
                        cause_d = IRQ_FLAG | WORD_W'(11);
                    end else if (msi_en) begin
                        cause_d = IRQ_FLAG | WORD_W'(3);
                    end else begin
                        cause_d = IRQ_FLAG | WORD_W'(7);
                    end
                end
            end
            FLUSH: begin
                if (flush_ack) begin
                    state_d = COMMIT;
                    if (kind_q == KIND_TRAP && is_irq) begin
                        pc_d = commit_pc;
                    end
                end
            end
            COMMIT: begin
                state_d = REDIRECT;
                rpc_d   = target;
            end
            REDIRECT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and latch registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            kind_q  <= KIND_TRAP;
            cause_q <= '0;
            pc_q    <= '0;
            rpc_q   <= '0;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            cause_q <= cause_d;
            pc_q    <= pc_d;
            rpc_q   <= rpc_d;
        end
    end

    assign flush_req           = (state_q == FLUSH);
    assign csr_exception       = (state_q == COMMIT) && (kind_q == KIND_TRAP);
    assign csr_mret            = (state_q == COMMIT) && (kind_q == KIND_MRET);
    assign csr_exception_cause = csr_exception ? cause_q : '0;
    assign csr_exception_pc    = csr_exception ? pc_q : '0;
    assign redirect_valid      = (state_q == REDIRECT);
    assign redirect_pc         = rpc_q;
    assign busy                = (state_q != IDLE);

endmodule

// File: tb/tb_trap_controller.sv
// Testbench for trap_controller: directed scenarios plus randomized requests
// checked against a behavioural model of request selection and vector targets.
module tb_trap_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        exc_valid;
    logic [31:0] exc_cause;
    logic [31:0] exc_pc;
    logic        mret_valid;
    logic        irq_msi, irq_mti, irq_mei;
    logic [31:0] commit_pc;
    logic        flush_ack;
    logic        csr_interrupt_en;
    logic [31:0] csr_mie;
    logic [1:0]  csr_mtvec_mode;
    logic [29:0] csr_mtvec_base;
    logic [31:0] csr_mepc;
    logic        csr_exception, csr_mret;
    logic [31:0] csr_exception_cause, csr_exception_pc;
    logic        flush_req, redirect_valid, busy;
    logic [31:0] redirect_pc;

    int total = 0;
    int bad   = 0;

    trap_controller #(.WORD_W(32)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .exc_valid           (exc_valid),
        .exc_cause           (exc_cause),
        .exc_pc              (exc_pc),
        .mret_valid          (mret_valid),
        .irq_msi             (irq_msi),
        .irq_mti             (irq_mti),
        .irq_mei             (irq_mei),
        .commit_pc           (commit_pc),
        .flush_ack           (flush_ack),
        .csr_interrupt_en    (csr_interrupt_en),
        .csr_mie             (csr_mie),
        .csr_mtvec_mode      (csr_mtvec_mode),
        .csr_mtvec_base      (csr_mtvec_base),
        .csr_mepc            (csr_mepc),
        .csr_exception       (csr_exception),
        .csr_mret            (csr_mret),
        .csr_exception_cause (csr_exception_cause),
        .csr_exception_pc    (csr_exception_pc),
        .flush_req           (flush_req),
        .redirect_valid      (redirect_valid),
        .redirect_pc         (redirect_pc),
        .busy                (busy)
    );

    always #5 clk = ~clk;

    // Reference: which request IDLE takes, by priority exc > mret > MEI > MSI > MTI.
    function automatic void model_pick(
        input  logic        exc, mret, msi, mti, mei, ie,
        input  logic [31:0] mie, ecause, epc,
        output logic        req, is_mret, is_irq,
        output logic [31:0] cause, pc);
        req = 1'b1; is_mret = 1'b0; is_irq = 1'b0; cause = 32'd0; pc = 32'd0;
        if (exc) begin
            cause = ecause; pc = epc;
        end else if (mret) begin
            is_mret = 1'b1;
        end else if (mei && ie && mie[11]) begin
            is_irq = 1'b1; cause = 32'h8000_0000 + 32'd11;
        end else if (msi && ie && mie[3]) begin
            is_irq = 1'b1; cause = 32'h8000_0000 + 32'd3;
        end else if (mti && ie && mie[7]) begin
            is_irq = 1'b1; cause = 32'h8000_0000 + 32'd7;
        end else begin
            req = 1'b0;
        end
    endfunction

    // Reference: redirect target from mtvec/mepc with plain arithmetic.
    function automatic logic [31:0] model_target(
        input logic is_mret, is_irq, input logic [31:0] cause,
        input logic [1:0] mode, input logic [29:0] base, input logic [31:0] mepc);
        logic [31:0] vec;
        vec = 32'(base) * 32'd4;
        if (is_mret) return mepc;
        if (is_irq && mode == 2'd1) return vec + (cause - 32'h8000_0000) * 32'd4;
        return vec;
    endfunction

    task automatic idle_inputs();
        exc_valid = 1'b0; exc_cause = '0; exc_pc = '0; mret_valid = 1'b0;
        irq_msi = 1'b0; irq_mti = 1'b0; irq_mei = 1'b0;
        commit_pc = '0; flush_ack = 1'b0; csr_interrupt_en = 1'b0; csr_mie = '0;
        csr_mtvec_mode = '0; csr_mtvec_base = '0; csr_mepc = '0;
    endtask

    // One transaction from an IDLE negedge with request inputs already driven.
    task automatic txn(input int d, input bit keep_irq, input bit fix_cpc, input logic [31:0] cpc);
        logic req, is_mret, is_irq;
        logic [31:0] cause, pc, tgt, exp_pc;
        model_pick(exc_valid, mret_valid, irq_msi, irq_mti, irq_mei, csr_interrupt_en,
                   csr_mie, exc_cause, exc_pc, req, is_mret, is_irq, cause, pc);
        tgt = model_target(is_mret, is_irq, cause, csr_mtvec_mode, csr_mtvec_base, csr_mepc);
        @(negedge clk);
        total++; if (flush_req !== req) begin bad++; $display("FAIL flush_req_start got=%0b exp=%0b", flush_req, req); end
        if (!req) return;
        // Request inputs are garbage outside IDLE and must be ignored.
        exc_valid = 1'($urandom); mret_valid = 1'($urandom);
        exc_cause = $urandom & 32'h7fff_ffff; exc_pc = $urandom;
        commit_pc = fix_cpc ? cpc : $urandom;
        flush_ack = (d == 0);
        for (int j = 1; j <= d; j++) begin
            @(negedge clk);
            total++; if ({flush_req, busy} !== 2'b11) begin bad++; $display("FAIL flush_hold cyc=%0d got=%b exp=11", j, {flush_req, busy}); end
            commit_pc = fix_cpc ? cpc : $urandom;
            if (j == d) flush_ack = 1'b1;
        end
        exp_pc = is_irq ? commit_pc : pc;
        @(negedge clk);
        total++; if ({csr_exception, csr_mret} !== {~is_mret, is_mret}) begin bad++; $display("FAIL commit_pulse got=%b exp=%b", {csr_exception, csr_mret}, {~is_mret, is_mret}); end
        total++; if (csr_exception_cause !== cause) begin bad++; $display("FAIL commit_cause got=%h exp=%h", csr_exception_cause, cause); end
        total++; if (csr_exception_pc !== exp_pc) begin bad++; $display("FAIL commit_pc got=%h exp=%h", csr_exception_pc, exp_pc); end
        total++; if ({flush_req, redirect_valid, busy} !== 3'b001) begin bad++; $display("FAIL commit_ctl got=%b exp=001", {flush_req, redirect_valid, busy}); end
        flush_ack = 1'b0; exc_valid = 1'b0; mret_valid = 1'b0;
        if (!keep_irq) begin irq_msi = 1'b0; irq_mti = 1'b0; irq_mei = 1'b0; end
        @(negedge clk);
        total++; if ({redirect_valid, busy, csr_exception, csr_mret} !== 4'b1100) begin bad++; $display("FAIL redirect_ctl got=%b exp=1100", {redirect_valid, busy, csr_exception, csr_mret}); end
        total++; if (redirect_pc !== tgt) begin bad++; $display("FAIL redirect_pc got=%h exp=%h", redirect_pc, tgt); end
        total++; if ({csr_exception_cause, csr_exception_pc} !== 64'd0) begin bad++; $display("FAIL redirect_cause_pc got=%h exp=0", {csr_exception_cause, csr_exception_pc}); end
        @(negedge clk);
        total++; if ({redirect_valid, busy, flush_req} !== 3'b000) begin bad++; $display("FAIL back_idle got=%b exp=000", {redirect_valid, busy, flush_req}); end
    endtask

    task automatic test_reset();
        rst = 1'b1; idle_inputs();
        repeat (2) @(negedge clk);
        total++; if ({csr_exception, csr_mret, csr_exception_cause, csr_exception_pc, flush_req, redirect_valid, redirect_pc, busy} !== '0) begin bad++; $display("FAIL reset_outputs got=%h exp=0", {csr_exception, csr_mret, csr_exception_cause, csr_exception_pc, flush_req, redirect_valid, redirect_pc, busy}); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_exception();
        idle_inputs();
        exc_valid = 1'b1; exc_cause = 32'd2; exc_pc = 32'h100;
        csr_mtvec_mode = 2'd0; csr_mtvec_base = 30'h40;
        txn(0, 1'b0, 1'b0, '0);
    endtask

    task automatic test_vectored_mti();
        idle_inputs();
        irq_mti = 1'b1; csr_mie = 32'h80; csr_interrupt_en = 1'b1;
        csr_mtvec_mode = 2'd1; csr_mtvec_base = 30'h100;
        txn(0, 1'b0, 1'b1, 32'h2C);
    endtask

    task automatic test_masking();
        for (int cfg = 0; cfg < 2; cfg++) begin
            idle_inputs();
            irq_mei = 1'b1;
            csr_mie = (cfg == 0) ? 32'h800 : 32'h0;
            csr_interrupt_en = (cfg == 0) ? 1'b0 : 1'b1;
            for (int c = 0; c < 20; c++) begin
                @(negedge clk);
                total++; if ({flush_req, busy} !== 2'b00) begin bad++; $display("FAIL masked_irq cfg=%0d cyc=%0d got=%b exp=00", cfg, c, {flush_req, busy}); end
            end
        end
        idle_inputs();
    endtask

    task automatic test_priority();
        idle_inputs();
        exc_valid = 1'b1; exc_cause = 32'd11; exc_pc = 32'h500;
        mret_valid = 1'b1; irq_mei = 1'b1; irq_msi = 1'b1;
        csr_mie = 32'h808; csr_interrupt_en = 1'b1; csr_mepc = 32'h9990;
        csr_mtvec_mode = 2'd1; csr_mtvec_base = 30'h20;
        txn(1, 1'b1, 1'b0, '0);
        // IRQs still pending and MIE still set: MEI wins over MSI.
        txn(0, 1'b1, 1'b0, '0);
        irq_mei = 1'b0;
        txn(2, 1'b0, 1'b0, '0);
    endtask

    task automatic test_mret_delay();
        int hold;
        idle_inputs();
        mret_valid = 1'b1; csr_mepc = 32'h1234;
        csr_mtvec_base = 30'h3000; csr_mtvec_mode = 2'd1;
        txn(5, 1'b0, 1'b0, '0);
        // Independently count how long flush_req stays up with a 5-cycle ack delay.
        mret_valid = 1'b1;
        @(negedge clk);
        mret_valid = 1'b0;
        hold = 0;
        for (int c = 0; c < 12; c++) begin
            if (flush_req) hold++;
            if (hold == 6) flush_ack = 1'b1;
            @(negedge clk);
            if (!flush_req) flush_ack = 1'b0;
        end
        total++; if (hold !== 6) begin bad++; $display("FAIL mret_flush_len got=%0d exp=6", hold); end
        idle_inputs();
    endtask

    task automatic test_reset_midflight();
        idle_inputs();
        exc_valid = 1'b1; exc_cause = 32'd5; exc_pc = 32'h300;
        @(negedge clk);
        exc_valid = 1'b0;
        total++; if (flush_req !== 1'b1) begin bad++; $display("FAIL rst_pre_flush got=%0b exp=1", flush_req); end
        rst = 1'b1; #1;
        total++; if ({csr_exception, csr_mret, csr_exception_cause, csr_exception_pc, flush_req, redirect_valid, redirect_pc, busy} !== '0) begin bad++; $display("FAIL rst_in_flush got=%h exp=0", {csr_exception, csr_mret, csr_exception_cause, csr_exception_pc, flush_req, redirect_valid, redirect_pc, busy}); end
        @(negedge clk);
        rst = 1'b0;
        exc_valid = 1'b1;
        @(negedge clk);
        exc_valid = 1'b0; flush_ack = 1'b1;
        @(negedge clk);
        total++; if (csr_exception !== 1'b1) begin bad++; $display("FAIL rst_pre_commit got=%0b exp=1", csr_exception); end
        rst = 1'b1; #1;
        total++; if ({csr_exception, csr_mret, csr_exception_cause, csr_exception_pc, flush_req, redirect_valid, redirect_pc, busy} !== '0) begin bad++; $display("FAIL rst_in_commit got=%h exp=0", {csr_exception, csr_mret, csr_exception_cause, csr_exception_pc, flush_req, redirect_valid, redirect_pc, busy}); end
        flush_ack = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total++; if ({csr_exception, redirect_valid, busy} !== 3'b000) begin bad++; $display("FAIL rst_after cyc=%0d got=%b exp=000", c, {csr_exception, redirect_valid, busy}); end
        end
        exc_valid = 1'b1; exc_cause = 32'd3; exc_pc = 32'h44;
        csr_mtvec_mode = 2'd0; csr_mtvec_base = 30'h10;
        txn(1, 1'b0, 1'b0, '0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            idle_inputs();
            exc_valid  = ($urandom_range(0, 3) == 0);
            mret_valid = ($urandom_range(0, 3) == 0);
            irq_msi = 1'($urandom); irq_mti = 1'($urandom); irq_mei = 1'($urandom);
            csr_interrupt_en = ($urandom_range(0, 3) != 0);
            csr_mie = $urandom;
            csr_mtvec_mode = 2'($urandom);
            csr_mtvec_base = 30'($urandom);
            csr_mepc = $urandom;
            exc_cause = $urandom & 32'h7fff_ffff;
            exc_pc = $urandom;
            txn($urandom_range(0, 3), 1'b0, 1'b0, '0);
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_exception();
        test_vectored_mti();
        test_masking();
        test_priority();
        test_mret_delay();
        test_reset_midflight();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
